if_inst_buffer: RTL and testbench

Instruction buffer between the AXI read adapter's instruction side and the IF/ID pipeline register. It accepts returned instruction words through the adapter's `inst`/`inst_valid`/`inst_read_ready` handshake and holds up to `DEPTH` words with their fetch addresses. It presents the oldest word to IF/ID, so the adapter completes reads while the pipeline is stalled. Words tagged as flushed (address zero) are discarded at entry, and a pipeline flush empties the buffer.

---
 rtl/if_inst_buffer_if.sv | 31 +++
 rtl/if_inst_buffer.sv | 95 +++++++++
 tb/tb_if_inst_buffer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/if_inst_buffer_if.sv
// Handshake bundle between the adapter/CTRL side and the instruction buffer.
interface if_inst_buffer_if #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DROP_W = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              inst_valid;
  logic [31:0]       inst;
  logic [31:0]       current_inst_address;
  logic              inst_read_ready;
  logic              flush;
  logic              stall;
  logic              if_valid;
  logic [31:0]       if_inst;
  logic [31:0]       if_pc;
  logic [CNT_W-1:0]  occupancy;
  logic [DROP_W-1:0] drop_count;

  // Driving side: adapter, CTRL and IF/ID.
  modport master (
    output inst_valid, inst, current_inst_address, flush, stall,
    input  inst_read_ready, if_valid, if_inst, if_pc, occupancy, drop_count
  );

  // Buffer side.
  modport slave (
    input  inst_valid, inst, current_inst_address, flush, stall,
    output inst_read_ready, if_valid, if_inst, if_pc, occupancy, drop_count
  );
endinterface

// File: rtl/if_inst_buffer.sv
// Instruction buffer: circular FIFO of {word, fetch address} between the AXI read
// adapter and IF/ID. Zero-address (flushed) words and words arriving during a
// pipeline flush are discarded and counted; a flush empties the buffer.
module if_inst_buffer #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DROP_W = 8
) (
  input logic               clk,
  input logic               reset,
  if_inst_buffer_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [31:0]       inst_mem [DEPTH];
  logic [31:0]       pc_mem   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic ready;
  logic not_empty;
  logic accept;
  logic enq;
  logic drop;
  logic deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Ready depends on registered count only, so the adapter sees no comb path.
  assign ready     = (count_q != FULL_CNT);
  assign not_empty = (count_q != '0);
  assign accept    = bus.inst_valid && ready;
  assign enq       = accept && !bus.flush && (bus.current_inst_address != 32'd0);
  assign drop      = accept && (bus.flush || (bus.current_inst_address == 32'd0));
  assign deq       = not_empty && !bus.stall && !bus.flush;

  // Next-state for pointers, count and the saturating drop counter.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (bus.flush) begin
      // Stored entries vanish silently; only a concurrent accept is a drop.
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (enq) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (enq && !deq) begin
        count_d = count_q + 1'b1;
      end else if (!enq && deq) begin
        count_d = count_q - 1'b1;
      end
    end
    if (drop && (drop_q != '1)) drop_d = drop_q + 1'b1;
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage; contents are don't-care until count covers them.
  always_ff @(posedge clk) begin
    if (enq && !reset) begin
      inst_mem[wr_ptr_q] <= bus.inst;
      pc_mem[wr_ptr_q]   <= bus.current_inst_address;
    end
  end

  assign bus.inst_read_ready = ready;
  assign bus.if_valid        = not_empty;
  assign bus.if_inst         = not_empty ? inst_mem[rd_ptr_q] : 32'd0;
  assign bus.if_pc           = not_empty ? pc_mem[rd_ptr_q] : 32'd0;
  assign bus.occupancy       = count_q;
  assign bus.drop_count      = drop_q;

endmodule

// File: tb/tb_if_inst_buffer.sv
// Self-checking bench for if_inst_buffer: directed scenarios plus a random
// stream, all compared against a queue-based reference model.
module tb_if_inst_buffer;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic clk;
  logic reset;
  if_inst_buffer_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

  if_inst_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t model_q[$];
  int   model_drops;
  int   n_checks;
  int   n_fail;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Compare every DUT output against the model's view.
  task automatic check_all(input string tag);
    ent_t head;
    bit   has = (model_q.size() != 0);
    if (has) head = model_q[0];
    check_val({tag, ".ready"}, 32'(bus.inst_read_ready), 32'(model_q.size() != DEPTH));
    check_val({tag, ".valid"}, 32'(bus.if_valid), 32'(has));
    check_val({tag, ".inst"}, bus.if_inst, has ? head.inst : 32'd0);
    check_val({tag, ".pc"}, bus.if_pc, has ? head.pc : 32'd0);
    check_val({tag, ".occ"}, 32'(bus.occupancy), 32'(model_q.size()));
    check_val({tag, ".drop"}, 32'(bus.drop_count), 32'(model_drops));
  endtask

  // One clock with the given inputs; acc reports whether the model expects an accept.
  task automatic cycle(input bit v, input logic [31:0] word, input logic [31:0] addr,
                       input bit fl, input bit st, input string tag, output bit acc);
    bit ready_m;
    bit had_head;
    bus.inst_valid           = v;
    bus.inst                 = word;
    bus.current_inst_address = addr;
    bus.flush                = fl;
    bus.stall                = st;
    ready_m  = (model_q.size() != DEPTH);
    had_head = (model_q.size() != 0);
    acc      = v && ready_m;
    @(posedge clk);
    #1;
    if (fl) begin
      model_q.delete();
      if (acc && model_drops < DROP_MAX) model_drops++;
    end else begin
      if (had_head && !st) void'(model_q.pop_front());
      if (acc) begin
        if (addr == 32'd0) begin
          if (model_drops < DROP_MAX) model_drops++;
        end else begin
          model_q.push_back('{inst: word, pc: addr});
        end
      end
    end
    check_all(tag);
  endtask

  task automatic idle(input bit st, input string tag);
    bit acc;
    cycle(1'b0, 32'd0, 32'd0, 1'b0, st, tag, acc);
  endtask

  task automatic do_reset();
    bus.inst_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.stall      = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_q.delete();
    model_drops = 0;
  endtask

  initial begin
    bit          acc;
    logic [31:0] w;
    logic [31:0] a;
    bit          pend;
    int          sent;
    n_checks    = 0;
    n_fail      = 0;
    model_drops = 0;
    bus.inst_valid           = 1'b0;
    bus.inst                 = 32'd0;
    bus.current_inst_address = 32'd0;
    bus.flush                = 1'b0;
    bus.stall                = 1'b0;
    reset = 1'b1;
    #1;
    check_val("rst_async_valid", 32'(bus.if_valid), 32'd0);
    do_reset();
    check_all("reset");

    // Basic flow: one word in, out one cycle later, drains the next.
    cycle(1'b1, 32'h24010001, 32'hBFC00000, 1'b0, 1'b0, "basic_in", acc);
    check_val("basic_inst", bus.if_inst, 32'h24010001);
    check_val("basic_pc", bus.if_pc, 32'hBFC00000);
    check_val("basic_occ1", 32'(bus.occupancy), 32'd1);
    idle(1'b0, "basic_drain");
    check_val("basic_occ0", 32'(bus.occupancy), 32'd0);

    // Fill under stall: A, B stored, C held off until A dequeues.
    cycle(1'b1, 32'hA0A0A0A0, 32'h1000, 1'b0, 1'b1, "fill_a", acc);
    cycle(1'b1, 32'hB0B0B0B0, 32'h1004, 1'b0, 1'b1, "fill_b", acc);
    cycle(1'b1, 32'hC0C0C0C0, 32'h1008, 1'b0, 1'b1, "fill_c_held", acc);
    check_val("fill_c_rejected", 32'(acc), 32'd0);
    check_val("fill_full_ready", 32'(bus.inst_read_ready), 32'd0);
    cycle(1'b1, 32'hC0C0C0C0, 32'h1008, 1'b0, 1'b0, "fill_deq_a", acc);
    check_val("fill_c_still_held", 32'(acc), 32'd0);
    check_val("fill_head_b", bus.if_inst, 32'hB0B0B0B0);
    cycle(1'b1, 32'hC0C0C0C0, 32'h1008, 1'b0, 1'b0, "fill_acc_c", acc);
    check_val("fill_c_taken", 32'(acc), 32'd1);
    check_val("fill_head_c", bus.if_inst, 32'hC0C0C0C0);
    idle(1'b0, "fill_drain");

    // Flush with two stored entries: empties, drop count unchanged.
    cycle(1'b1, 32'h11111111, 32'h2000, 1'b0, 1'b1, "fl_a", acc);
    cycle(1'b1, 32'h22222222, 32'h2004, 1'b0, 1'b1, "fl_b", acc);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, "fl_flush", acc);
    check_val("fl_occ0", 32'(bus.occupancy), 32'd0);
    check_val("fl_drop_same", 32'(bus.drop_count), 32'd0);
    cycle(1'b1, 32'h33333333, 32'h2008, 1'b0, 1'b0, "fl_next", acc);
    check_val("fl_next_inst", bus.if_inst, 32'h33333333);
    idle(1'b0, "fl_drain");

    // Flushed tag and accept during flush both count as drops.
    cycle(1'b1, 32'h12345678, 32'd0, 1'b0, 1'b0, "tag_zero", acc);
    check_val("tag_valid0", 32'(bus.if_valid), 32'd0);
    check_val("tag_drop1", 32'(bus.drop_count), 32'd1);
    cycle(1'b1, 32'h87654321, 32'h3000, 1'b1, 1'b0, "tag_flush", acc);
    check_val("tag_drop2", 32'(bus.drop_count), 32'd2);

    // Random stream with stalls, zero tags and occasional flushes across wraps.
    pend = 1'b0;
    sent = 0;
    w    = 32'd0;
    a    = 32'd0;
    for (int i = 0; i < 600 && sent < 60; i++) begin
      if (!pend) begin
        w    = $urandom;
        a    = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom | 32'h4);
        pend = ($urandom_range(0, 3) != 0);
      end
      cycle(pend, w, a, (i > 30) && ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 1) == 0), "rnd", acc);
      if (acc) begin
        pend = 1'b0;
        sent++;
      end
    end
    check_val("rnd_progress", 32'(sent >= 20), 32'd1);
    for (int i = 0; i < 8 && model_q.size() != 0; i++) idle(1'b0, "rnd_drain");
    check_val("rnd_empty", 32'(bus.if_valid), 32'd0);

    // Saturation: 300 discards pin the counter at all-ones.
    do_reset();
    for (int i = 0; i < 300; i++) cycle(1'b1, i, 32'd0, 1'b0, 1'b0, "sat", acc);
    check_val("sat_255", 32'(bus.drop_count), 32'd255);

    // Async reset between edges with entries present.
    cycle(1'b1, 32'h55555555, 32'h4000, 1'b0, 1'b1, "ar_a", acc);
    cycle(1'b1, 32'h66666666, 32'h4004, 1'b0, 1'b1, "ar_b", acc);
    #2;
    reset = 1'b1;
    #1;
    check_val("ar_valid", 32'(bus.if_valid), 32'd0);
    check_val("ar_inst", bus.if_inst, 32'd0);
    check_val("ar_pc", bus.if_pc, 32'd0);
    check_val("ar_occ", 32'(bus.occupancy), 32'd0);
    check_val("ar_drop", 32'(bus.drop_count), 32'd0);
    check_val("ar_ready", 32'(bus.inst_read_ready), 32'd1);
    do_reset();
    cycle(1'b1, 32'h77777777, 32'h5000, 1'b0, 1'b0, "ar_after", acc);
    check_val("ar_after_inst", bus.if_inst, 32'h77777777);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
